// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, reads instruction memory and
// presents one instruction slot per cycle to decode, with stall, wait-state and redirect handling.
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_read,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_resp,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_ir,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [3:0]         if_opcode,
    output logic               if_ir4,
    output logic               if_ir5,
    output logic               if_ir11
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_HOLD  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   pc_r, pc_s;
    logic [ADDR_W-1:0]   drain_addr_r, drain_addr_s;
    logic [INSTR_W-1:0]  hold_r, hold_s;
    logic [INSTR_W-1:0]  ir_r, ir_s;
    logic [ADDR_W-1:0]   ifpc_r, ifpc_s;
    logic                valid_r, valid_s;
    logic                slot_free_s;
    logic [ADDR_W-1:0]   pc_inc_s;

    // Next-state and next-slot computation for the fetch controller
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        drain_addr_s = drain_addr_r;
        hold_s       = hold_r;
        ir_s         = ir_r;
        ifpc_s       = ifpc_r;
        valid_s      = valid_r;
        slot_free_s  = ~valid_r | ~stall;
        pc_inc_s     = pc_r + ADDR_W'(2);

        case (state_r)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_s    = redirect_pc;
                    valid_s = 1'b0;
                    if (imem_resp) begin
                        state_s = ST_FETCH;
                    end else begin
                        // keep the in-flight address on the bus until its response drains
                        drain_addr_s = pc_r;
                        state_s      = ST_DRAIN;
                    end
                end else if (imem_resp) begin
                    if (slot_free_s) begin
                        ir_s    = imem_rdata;
                        ifpc_s  = pc_inc_s;
                        valid_s = 1'b1;
                        pc_s    = pc_inc_s;
                    end else begin
                        hold_s  = imem_rdata;
                        state_s = ST_HOLD;
                    end
                end else if (slot_free_s) begin
                    valid_s = 1'b0;
                end else begin
                    valid_s = valid_r;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    hold_s  = {INSTR_W{1'b0}};
                    valid_s = 1'b0;
                    pc_s    = redirect_pc;
                    state_s = ST_FETCH;
                end else if (!stall) begin
                    ir_s    = hold_r;
                    ifpc_s  = pc_inc_s;
                    valid_s = 1'b1;
                    pc_s    = pc_inc_s;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                valid_s = 1'b0;
                if (redirect_valid) begin
                    pc_s = redirect_pc;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_resp) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_FETCH;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output-slot registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            drain_addr_r <= {ADDR_W{1'b0}};
            hold_r       <= {INSTR_W{1'b0}};
            ir_r         <= {INSTR_W{1'b0}};
            ifpc_r       <= {ADDR_W{1'b0}};
            valid_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            drain_addr_r <= drain_addr_s;
            hold_r       <= hold_s;
            ir_r         <= ir_s;
            ifpc_r       <= ifpc_s;
            valid_r      <= valid_s;
        end
    end

    // Request is idle only while holding a word or while in reset
    assign imem_read    = reset_n & (state_r != ST_HOLD);
    assign imem_address = (state_r == ST_DRAIN) ? drain_addr_r : pc_r;

    assign if_valid  = valid_r;
    assign if_ir     = ir_r;
    assign if_pc     = ifpc_r;
    assign if_opcode = ir_r[15:12];
    assign if_ir4    = ir_r[4];
    assign if_ir5    = ir_r[5];
    assign if_ir11   = ir_r[11];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed walk through the key scenarios,
// then randomized memory latency, stalls and redirects against a stream-level model.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [15:0] if_ir;
    logic [15:0] if_pc;
    logic [3:0]  if_opcode;
    logic        if_ir4;
    logic        if_ir5;
    logic        if_ir11;

    int errors;
    int checks;

    fetch_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_ir          (if_ir),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode),
        .if_ir4         (if_ir4),
        .if_ir5         (if_ir5),
        .if_ir11        (if_ir11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // memory image used in the random phase: distinct word per address
    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    task automatic run_cycle(input logic st, input logic rv, input logic [15:0] rpc,
                             input logic rsp, input logic [15:0] rd);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_resp      = rsp;
        imem_rdata     = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic v, input logic [15:0] ir, input logic [15:0] pc);
        check_eq({tag, "_valid"}, 16'(if_valid), 16'(v));
        check_eq({tag, "_ir"}, if_ir, ir);
        check_eq({tag, "_pc"}, if_pc, pc);
    endtask

    task automatic check_req(input string tag, input logic rd, input logic [15:0] addr);
        check_eq({tag, "_read"}, 16'(imem_read), 16'(rd));
        if (rd) check_eq({tag, "_addr"}, imem_address, addr);
    endtask

    // random-phase model state
    logic        outst;
    logic [15:0] req_addr;
    int          wait_left;
    logic [15:0] exp_addr;
    logic        held_prev;
    logic        redir_prev;
    logic [15:0] prev_ir;
    logic [15:0] prev_pc;
    int          consumed;
    logic        st_v;
    logic        rv_v;
    logic [15:0] rpc_v;
    logic        rsp_v;
    logic [15:0] rd_v;
    logic [15:0] w;

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        imem_resp = 1'b0;
        imem_rdata = 16'h0000;

        // reset state, with a stray response that must be ignored
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'hABCD);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_slot("reset", 1'b0, 16'h0000, 16'h0000);
        check_eq("reset_read", 16'(imem_read), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_req("release", 1'b1, 16'h0000);

        // zero-wait stream
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1001);
        check_slot("zw0", 1'b1, 16'h1001, 16'h0002);
        check_eq("zw0_op", 16'(if_opcode), 16'd1);
        check_req("zw0", 1'b1, 16'h0002);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5042);
        check_slot("zw1", 1'b1, 16'h5042, 16'h0004);
        check_eq("zw1_op", 16'(if_opcode), 16'd5);
        check_eq("zw1_bits", 16'({if_ir11, if_ir5, if_ir4}), 16'd0);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h9FFF);
        check_slot("zw2", 1'b1, 16'h9FFF, 16'h0006);
        check_eq("zw2_op", 16'(if_opcode), 16'd9);
        check_eq("zw2_bits", 16'({if_ir11, if_ir5, if_ir4}), 16'd7);

        // wait states: address stable for 4 cycles
        for (int i = 0; i < 3; i++) begin
            check_req("wait", 1'b1, 16'h0006);
            run_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
            check_eq("wait_valid", 16'(if_valid), 16'd0);
        end
        check_req("wait_last", 1'b1, 16'h0006);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222);
        check_slot("wait_done", 1'b1, 16'h2222, 16'h0008);

        // back-pressure into HOLD
        run_cycle(1'b1, 1'b0, 16'h0000, 1'b1, 16'h3333);
        for (int i = 0; i < 4; i++) begin
            check_slot("hold", 1'b1, 16'h2222, 16'h0008);
            check_eq("hold_read", 16'(imem_read), 16'd0);
            run_cycle(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        end
        check_slot("hold_last", 1'b1, 16'h2222, 16'h0008);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_slot("unhold", 1'b1, 16'h3333, 16'h000A);
        check_req("unhold", 1'b1, 16'h000A);

        // redirect coincident with resp while stalled
        run_cycle(1'b1, 1'b1, 16'h0010, 1'b1, 16'hBEEF);
        check_eq("redir_resp_valid", 16'(if_valid), 16'd0);
        check_req("redir_resp", 1'b1, 16'h0010);

        // redirect while read of 0x0010 outstanding
        run_cycle(1'b0, 1'b1, 16'h0300, 1'b0, 16'h0000);
        check_req("drain0", 1'b1, 16'h0010);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_req("drain1", 1'b1, 16'h0010);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD);
        check_eq("drain_valid", 16'(if_valid), 16'd0);
        check_req("drain_done", 1'b1, 16'h0300);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444);
        check_slot("post_drain", 1'b1, 16'h4444, 16'h0302);

        // redirect drops a held word
        run_cycle(1'b1, 1'b0, 16'h0000, 1'b1, 16'h5555);
        run_cycle(1'b1, 1'b1, 16'h0400, 1'b0, 16'h0000);
        check_eq("hold_redir_valid", 16'(if_valid), 16'd0);
        check_req("hold_redir", 1'b1, 16'h0400);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h6666);
        check_slot("hold_redir_next", 1'b1, 16'h6666, 16'h0402);

        // pc wrap
        run_cycle(1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0000);
        check_req("wrap_req", 1'b1, 16'hFFFE);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
        check_slot("wrap", 1'b1, 16'h7777, 16'h0000);
        check_req("wrap_next", 1'b1, 16'h0000);
        run_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h8888);
        check_req("pre_reset", 1'b1, 16'h0002);

        // asynchronous reset between edges
        #2;
        imem_resp = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("areset_valid", 16'(if_valid), 16'd0);
        check_eq("areset_read", 16'(imem_read), 16'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_req("areset_restart", 1'b1, 16'h0000);

        // randomized phase against a stream-level model
        outst = 1'b0;
        req_addr = 16'h0000;
        wait_left = 0;
        exp_addr = 16'h0000;
        held_prev = 1'b0;
        redir_prev = 1'b0;
        prev_ir = 16'h0000;
        prev_pc = 16'h0000;
        consumed = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (redir_prev) check_eq("rnd_flush", 16'(if_valid), 16'd0);
            if (held_prev) begin
                check_slot("rnd_stall_hold", 1'b1, prev_ir, prev_pc);
            end
            if (imem_read) begin
                if (!outst) begin
                    outst = 1'b1;
                    req_addr = imem_address;
                    wait_left = int'($urandom_range(0, 3));
                end else begin
                    check_eq("rnd_addr_stable", imem_address, req_addr);
                end
            end else if (outst) begin
                check_eq("rnd_read_dropped", 16'(imem_read), 16'd1);
            end
            st_v  = ($urandom_range(0, 3) == 0);
            rv_v  = ($urandom_range(0, 9) == 0);
            rpc_v = 16'($urandom()) & 16'hFFFE;
            rsp_v = outst && (wait_left == 0);
            rd_v  = rsp_v ? memf(req_addr) : 16'($urandom());
            if (outst && wait_left != 0) wait_left--;
            if (if_valid && !st_v && !rv_v) begin
                w = memf(exp_addr);
                check_eq("rnd_pc", if_pc, exp_addr + 16'd2);
                check_eq("rnd_ir", if_ir, w);
                check_eq("rnd_op", 16'(if_opcode), 16'(w[15:12]));
                check_eq("rnd_bits", 16'({if_ir11, if_ir5, if_ir4}), 16'({w[11], w[5], w[4]}));
                exp_addr = exp_addr + 16'd2;
                consumed++;
            end
            if (rv_v) exp_addr = rpc_v;
            held_prev  = if_valid && st_v && !rv_v;
            prev_ir    = if_ir;
            prev_pc    = if_pc;
            redir_prev = rv_v;
            if (rsp_v) outst = 1'b0;
            run_cycle(st_v, rv_v, rpc_v, rsp_v, rd_v);
        end
        check_eq("rnd_progress", 16'(consumed >= 100), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
